multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the memory-wait cycle limit before trap (4-bit counter range 1..15).
REQ-002 SHALL have port CLK, input, 1, the system clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have the following data inputs:
- Instr, input, 32: current IR; opcode [6:0], funct3 [14:12].
- Zero, input, 1: ALU zero flag.
- MemReady, input, 1: unified memory access complete.
REQ-005 SHALL have the following 1-bit control outputs:
- PCWrite, IRWrite, RegWrite, MemWrite.
- AdrSrc: 0 = PC, 1 = ALUOut.
REQ-006 SHALL have the following 2-bit mux outputs:
- ALUSrcA: 00 PC, 01 OldPC, 10 rs1.
- ALUSrcB: 00 rs2, 01 ExtImm, 10 const 4.
- ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUOp: 00 add, 01 sub/compare, 10 funct-decoded.
REQ-007 SHALL have the following immediate-extender outputs:
- ImmSrc, output, 3: Extend select.
- Sign, output, 1: Extend sign select.
REQ-008 SHALL have the following status outputs:
- State, output, 4: current state, for debug.
- Illegal, output, 1: illegal opcode trap.
- MemErr, output, 1: memory timeout trap.

Function
REQ-009 SHALL implement a Moore FSM with these state encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5.
- EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JALR=10, JUMP=11, TRAP=12.
REQ-010 SHALL take these transitions:
- FETCH -> DECODE.
- DECODE on opcode:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JUMP.
  - 1100111 -> JALR.
  - any other -> TRAP.
REQ-011 SHALL take these further transitions:
- MEMADR -> MEMREAD for lw, MEMWRITE for sw.
- MEMREAD -> MEMWB.
- EXECR and EXECI -> ALUWB.
- JALR -> JUMP.
- JUMP -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
- TRAP is terminal until Reset.
REQ-012 SHALL drive non-zero outputs per state as follows; every unlisted output is 0:
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR and JALR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- EXECR: ALUSrcA=10, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BRANCH: ALUSrcA=10, ALUOp=01.
- JUMP: PCWrite=1, ALUSrcA=01, ALUSrcB=10.
REQ-013 SHALL drive PCWrite in BRANCH as Zero XOR Instr[12], the only Mealy output (beq taken on Zero=1, bne taken on Zero=0).
REQ-014 SHALL decode ImmSrc combinationally from the Instr opcode:
- R-type -> 1.
- I-type, lw and jalr -> 2.
- sw -> 3.
- branch -> 4.
- jal -> 5.
- any other -> 0.
REQ-015 SHALL drive Sign=0 only for opcode 0010011 with funct3=011 (sltiu), and Sign=1 otherwise.
REQ-016 SHALL assert Illegal and MemErr only in TRAP; all control outputs SHALL be 0 in TRAP.
REQ-017 SHALL take one cycle per state, except waits per REQ-021; latency is lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5 cycles.

Reset
REQ-018 SHALL force State to FETCH and clear the wait counter immediately on Reset high, mid-instruction included.
REQ-019 SHALL hold every output at 0 while Reset is high, including PCWrite, IRWrite, Illegal and MemErr.
REQ-020 SHALL perform the first fetch write on the first rising edge after Reset falls.

Configuration
REQ-021 SHALL, with MEM_WAIT_EN defined, behave as follows:
- FETCH, MEMREAD and MEMWRITE hold the state while MemReady=0.
- In FETCH, IRWrite and PCWrite are gated by MemReady.
- A 4-bit wait counter increments each held cycle and clears on leaving the state.
- When the counter reaches TIMEOUT with MemReady still 0, the next state is TRAP with MemErr=1.
- MemReady=1 on the TIMEOUT cycle completes normally.
REQ-022 SHALL, without MEM_WAIT_EN, ignore MemReady, omit the counter and tie MemErr to 0.

Structure
REQ-023 SHALL place the state encodings, opcode constants, ImmSrc codes (1..5) and mux select codes in package ctrl_pkg.
REQ-024 SHALL place the ImmSrc/Sign decode in sub-module imm_decode; the FSM and counter stay in multicycle_ctrl.

Verification
REQ-025 SHALL cover add x1,x2,x3 (0x003100B3), which SHALL give states 0,1,6,8,0, RegWrite=1 only in state 8, and ImmSrc=1.
REQ-026 SHALL cover beq with Zero=1, then bne with Zero=1, which SHALL give PCWrite=1 in BRANCH for beq and 0 for bne, with ImmSrc=4.
REQ-027 SHALL cover lw with MEM_WAIT_EN and MemReady low 3 cycles in MEMREAD, which SHALL hold State=3 for 4 cycles, then MEMWB with ResultSrc=01.
REQ-028 SHALL cover MemReady held 0 in FETCH with TIMEOUT=15, which SHALL give TRAP after 15 wait cycles, MemErr=1, and IRWrite never asserted.
REQ-029 SHALL cover opcode 0x7F, which SHALL give State=12 and Illegal=1 until Reset; Reset asserted in MEMWRITE SHALL drop MemWrite to 0 the same cycle.
REQ-030 SHALL cover jalr, which SHALL give states 1,10,11,8, Sign=1, and PCWrite=1 only in JUMP.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encodings, opcodes, ImmSrc codes and datapath mux selects for multicycle_ctrl.
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_R    = 3'd1;
  localparam logic [2:0] IMM_I    = 3'd2;
  localparam logic [2:0] IMM_S    = 3'd3;
  localparam logic [2:0] IMM_B    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: immediate-format select and sign select decoded from the opcode and funct3.
module imm_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output logic [2:0] o_imm_src,
  output logic       o_sign
);
  always_comb begin
    o_imm_src = (i_opcode == OP_R) ? IMM_R :
                (i_opcode == OP_I || i_opcode == OP_LW || i_opcode == OP_JALR) ? IMM_I :
                (i_opcode == OP_SW) ? IMM_S :
                (i_opcode == OP_BR) ? IMM_B :
                (i_opcode == OP_JAL) ? IMM_J : IMM_NONE;
    o_sign = !(i_opcode == OP_I && i_funct3 == F3_SLTIU);
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32 control FSM with illegal-opcode trap.
// Define MEM_WAIT_EN to stall on MemReady with a TIMEOUT-cycle memory trap.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUOp,
  output logic [2:0]  ImmSrc,
  output logic        Sign,
  output logic [3:0]  State,
  output logic        Illegal,
  output logic        MemErr
);
  localparam logic [3:0] TO = TIMEOUT[3:0];
  state_t r_state, w_next;
  logic [6:0] w_op;
  logic [2:0] w_imm;
  logic w_sign, w_hold, w_timeout, w_memerr, w_unused;
  assign w_op = Instr[6:0];
  imm_decode u_imm (
    .i_opcode (w_op),
    .i_funct3 (Instr[14:12]),
    .o_imm_src(w_imm),
    .o_sign   (w_sign)
  );
`ifdef MEM_WAIT_EN
  logic [3:0] r_cnt;
  logic r_memerr;
  assign w_hold = (r_state == S_FETCH || r_state == S_MEMREAD || r_state == S_MEMWRITE) && !MemReady;
  assign w_timeout = w_hold && r_cnt == TO;
  assign w_memerr = r_memerr;
  assign w_unused = ^{Instr[31:15], Instr[11:7]};
  // r_memerr remembers why TRAP was entered so Illegal and MemErr stay exclusive
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      r_cnt <= '0;
      r_memerr <= 1'b0;
    end else begin
      r_cnt <= (w_hold && !w_timeout) ? r_cnt + 4'd1 : '0;
      r_memerr <= r_memerr | w_timeout;
    end
`else
  assign w_hold = 1'b0;
  assign w_timeout = 1'b0;
  assign w_memerr = 1'b0;
  assign w_unused = ^{Instr[31:15], Instr[11:7], MemReady, TO};
`endif
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) r_state <= S_FETCH;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE:   w_next = (w_op == OP_LW || w_op == OP_SW) ? S_MEMADR :
                           (w_op == OP_R) ? S_EXECR :
                           (w_op == OP_I) ? S_EXECI :
                           (w_op == OP_BR) ? S_BRANCH :
                           (w_op == OP_JAL) ? S_JUMP :
                           (w_op == OP_JALR) ? S_JALR : S_TRAP;
      S_MEMADR:   w_next = (w_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JUMP: w_next = S_ALUWB;
      S_JALR:     w_next = S_JUMP;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: w_next = S_FETCH;
      default:    w_next = r_state;
    endcase
    if (w_hold) w_next = w_timeout ? S_TRAP : r_state;
  end
  always_comb begin
    {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc} = '0;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    ALUOp = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        IRWrite = !w_hold;
        PCWrite = !w_hold;
        ALUSrcB = SRCB_4;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR, S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWRITE: {AdrSrc, MemWrite} = 2'b11;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUOp = ALU_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp = ALU_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUOp = ALU_SUB;
        PCWrite = Zero ^ Instr[12];
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
      end
      default: ;
    endcase
    if (Reset) {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp} = '0;
  end
  assign State = r_state;
  assign Illegal = r_state == S_TRAP && !w_memerr;
  assign MemErr = r_state == S_TRAP && w_memerr;
  assign ImmSrc = Reset ? IMM_NONE : w_imm;
  assign Sign = !Reset && w_sign;
endmodule
